mem_arbiter: RTL and testbench

//  Two-requester controller for the 8-word x 8-bit memory array (RW, 3-bit address, shared write data, 8 word outputs).

---
 rtl/mem_ctrl_pkg.sv | 9 +
 rtl/rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, FSM encoding and RW levels for the memory controller.
package mem_ctrl_pkg;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NWORDS = 2 ** AW;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CAPTURE, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick with a registered last-grant pointer (bit 0 = A, bit 1 = B).
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);
    logic last_b;
    always_comb gnt = (req == 2'b11) ? (last_b ? 2'b01 : 2'b10) : req;
    // Reset points at B so that A wins the first contested pick.
    always_ff @(posedge clk) begin
        if (rst) last_b <= 1'b1;
        else if (adv && |req) last_b <= gnt[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester controller sequencing fixed-phase accesses to an 8x8 memory array.
module mem_arbiter #(
    parameter int DW = mem_ctrl_pkg::DW,
    parameter int AW = mem_ctrl_pkg::AW,
    parameter int WR_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic [DW-1:0]        a_wdata,
    output logic                 a_gnt,
    output logic                 a_done,
    output logic [DW-1:0]        a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic [DW-1:0]        b_wdata,
    output logic                 b_gnt,
    output logic                 b_done,
    output logic [DW-1:0]        b_rdata,
    output logic                 busy,
    output logic                 mem_rw,
    output logic [AW-1:0]        mem_adr,
    output logic [DW-1:0]        mem_i,
    input  logic [DW*(2**AW)-1:0] mem_o
);
    import mem_ctrl_pkg::*;
    state_t state;
    logic [2:0] cnt;
    logic we_l;
    logic own_b;
    logic [1:0] pick;
    logic [DW-1:0] word;
    assign word = mem_o[DW*mem_adr +: DW];
    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({b_req, a_req}),
        .adv (state == IDLE),
        .gnt (pick)
    );
    // mem_adr/mem_i double as the request latch, so they stay put from SETUP through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            we_l <= 1'b0;
            own_b <= 1'b0;
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            busy <= 1'b0;
            mem_rw <= RW_READ;
            mem_adr <= '0;
            mem_i <= '0;
        end else begin
            case (state)
                IDLE: if (|pick) begin
                    state <= SETUP;
                    own_b <= pick[1];
                    we_l <= pick[1] ? b_we : a_we;
                    mem_adr <= pick[1] ? b_addr : a_addr;
                    mem_i <= pick[1] ? b_wdata : a_wdata;
                    a_gnt <= pick[0];
                    b_gnt <= pick[1];
                    busy <= 1'b1;
                end
                SETUP: begin
                    state <= we_l ? STROBE : CAPTURE;
                    mem_rw <= we_l ? RW_WRITE : RW_READ;
                    cnt <= '0;
                end
                STROBE: if (cnt == 3'(WR_CYCLES - 1)) begin
                    state <= HOLD;
                    mem_rw <= RW_READ;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                HOLD, CAPTURE: begin
                    state <= DONE;
                    a_done <= !own_b;
                    b_done <= own_b;
                    if (state == CAPTURE && own_b) b_rdata <= word;
                    if (state == CAPTURE && !own_b) a_rdata <= word;
                end
                DONE: begin
                    state <= IDLE;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    a_gnt <= 1'b0;
                    b_gnt <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench with a transaction-level arbitration/memory reference model.
module tb_mem_arbiter;
    localparam int W = 2;
    logic clk = 0;
    logic rst = 1;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [2:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic a_gnt, a_done, b_gnt, b_done, busy, mem_rw;
    logic [7:0] a_rdata, b_rdata, mem_i;
    logic [2:0] mem_adr;
    logic [63:0] mem_o;
    logic [7:0] mem [8];
    logic [7:0] ref_mem [8];
    logic [7:0] exp_rd [2];
    typedef struct {int own; int de; bit rd; logic [7:0] d;} exp_t;
    exp_t q[$];
    int cyc = 0, next_ok = 0, m_own = -1, m_start = 0, m_done = 0;
    bit last_b = 1;
    int checks = 0, errs = 0, run = 0;
    logic [2:0] run_adr;
    logic [7:0] run_dat;

    mem_arbiter #(.WR_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .busy(busy), .mem_rw(mem_rw), .mem_adr(mem_adr), .mem_i(mem_i), .mem_o(mem_o)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 8; i++) begin
        mem[i] = 0;
        ref_mem[i] = 0;
    end
    always @(posedge clk) if (!mem_rw) mem[mem_adr] <= mem_i;
    for (genvar k = 0; k < 8; k++) begin : g_mo
        assign mem_o[8*k +: 8] = mem[k];
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // Reference model: one access at a time, contested picks go to whoever was not served last.
    always @(posedge clk) begin
        int own, de;
        bit we;
        logic [2:0] ad;
        cyc++;
        if (rst) begin
            q.delete();
            last_b = 1;
            next_ok = cyc + 1;
            m_own = -1;
            exp_rd[0] = 0;
            exp_rd[1] = 0;
        end else if (cyc >= next_ok && (a_req || b_req)) begin
            own = (a_req && b_req) ? (last_b ? 0 : 1) : (b_req ? 1 : 0);
            last_b = (own == 1);
            we = own ? b_we : a_we;
            ad = own ? b_addr : a_addr;
            if (we) ref_mem[ad] = own ? b_wdata : a_wdata;
            de = cyc + 2 + (we ? W : 0);
            q.push_back('{own, de, !we, ref_mem[ad]});
            m_own = own;
            m_start = cyc;
            m_done = de;
            next_ok = de + 2;
        end
    end

    always @(negedge clk) begin
        if (rst) run = 0;
        else begin
            bit hit, act;
            int ow;
            hit = q.size() > 0 && q[0].de == cyc;
            ow = hit ? q[0].own : -1;
            act = cyc >= m_start && cyc <= m_done;
            chk("a_done", a_done, ow == 0);
            chk("b_done", b_done, ow == 1);
            chk("a_gnt", a_gnt, m_own == 0 && act);
            chk("b_gnt", b_gnt, m_own == 1 && act);
            chk("busy", busy, m_own >= 0 && act);
            if (hit) begin
                if (q[0].rd) exp_rd[ow] = q[0].d;
                void'(q.pop_front());
            end
            chk("a_rdata", a_rdata, exp_rd[0]);
            chk("b_rdata", b_rdata, exp_rd[1]);
            if (!mem_rw) begin
                if (run == 0) begin
                    run_adr = mem_adr;
                    run_dat = mem_i;
                end else begin
                    chk("strobe_adr_stable", mem_adr, run_adr);
                    chk("strobe_dat_stable", mem_i, run_dat);
                end
                run++;
            end else begin
                if (run > 0) chk("strobe_len", run, W);
                run = 0;
            end
        end
    end

    task automatic issue(int who, bit we, logic [2:0] ad, logic [7:0] wd, bit drop);
        int t = 0;
        if (who == 0) begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
        else begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
        do begin
            @(negedge clk);
            t++;
            if (drop && who == 0 && a_gnt) a_req = 0;
            if (drop && who == 1 && b_gnt) b_req = 0;
        end while (!(who ? b_done : a_done) && t < 200);
        chk(who ? "b_done_timeout" : "a_done_timeout", t < 200, 1);
        if (who == 0) a_req = 0; else b_req = 0;
    endtask

    task automatic run_rand(int who, int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(who, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_mem_rw", mem_rw, 1);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_i", mem_i, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_rdata", a_rdata, 0);
        issue(0, 1, 5, 8'hA5, 0);
        issue(0, 0, 5, 8'h00, 0);
        chk("a_read_back_A5", a_rdata, 8'hA5);
        for (int p = 0; p < 2; p++) fork
            issue(0, 0, 3'(p), 8'h00, 0);
            issue(1, 1, 3'(p + 1), 8'(8'h40 + p), 0);
        join
        fork
            repeat (3) issue(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 0);
            repeat (3) issue(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 0);
        join
        fork
            issue(1, 1, 7, 8'h3C, 0);
            begin
                repeat (2) @(negedge clk);
                issue(0, 0, 7, 8'h00, 0);
            end
        join
        chk("a_reads_b_write", a_rdata, 8'h3C);
        // Rewrite a word with its current contents so an abandoned strobe leaves memory unchanged.
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = ref_mem[3];
        t = 0;
        do begin @(negedge clk); t++; end while (mem_rw && t < 20);
        chk("strobe_seen", t < 20, 1);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        a_req = 0;
        chk("rst_mid_rw", mem_rw, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", a_done, 0);
        chk("rst_mid_gnt", a_gnt, 0);
        @(negedge clk);
        issue(0, 0, 5, 8'h00, 0);
        chk("after_rst_read", a_rdata, 8'hA5);
        fork
            run_rand(0, 40);
            run_rand(1, 40);
        join
        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, got cycle %0d required finish", cyc);
        $fatal(1);
    end
endmodule
